fp_resource_arbiter: RTL and testbench
======================================

FP_RESOURCE_ARBITER -- requirements
Module: fp_resource_arbiter

Interface
REQ-001 The block SHALL take parameter PRECISION, default 32, selecting the operand width; legal values are 32 and 64.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Req, input, 2 bits: per-requester add/sub job request.
REQ-005 The block SHALL have port ReqA, input, 2*PRECISION bits: operand A, requester r in slice [r*PRECISION +: PRECISION].
REQ-006 The block SHALL have port ReqB, input, 2*PRECISION bits: operand B, sliced as ReqA.
REQ-007 The block SHALL have port ReqOp, input, 2 bits: per requester, 0 = add, 1 = subtract.
REQ-008 The block SHALL have port Gnt, output, 2 bits: one-cycle pulse meaning job accepted and operands latched.
REQ-009 The block SHALL have port Done, output, 2 bits: one-cycle pulse meaning Result is valid for that requester.
REQ-010 The block SHALL have port Result, output, PRECISION bits: last completed sum, held until the next Done.
REQ-011 The block SHALL have port Busy, output, 1 bit: 1 whenever the state is not IDLE.
REQ-012 The block SHALL have ports toAddA and toAddB, outputs, PRECISION bits each: operands to the shared adder.
REQ-013 The block SHALL have port toAddOp, output, 1 bit: operation to the shared adder.
REQ-014 The block SHALL have port toAddLoad, output, 1 bit: start pulse to the shared adder.
REQ-015 The block SHALL have port fromAddValid, input, 1 bit: adder completion.
REQ-016 The block SHALL have port fromAddOut, input, PRECISION bits: adder result.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and WAIT, all outputs registered.
REQ-018 In IDLE with Req != 0, the block SHALL pick one requester round-robin, latch its ReqA/ReqB/ReqOp slice into toAddA/toAddB/toAddOp, pulse its Gnt bit for 1 cycle, and enter ISSUE.
REQ-019 Round-robin: with both Req bits set, the requester not served last SHALL win; with one bit set, that requester SHALL win regardless of the pointer.
REQ-020 In ISSUE, toAddLoad SHALL be 1 for exactly one cycle, then the state SHALL go to WAIT.
REQ-021 fromAddValid SHALL be ignored in IDLE and ISSUE.
REQ-022 In WAIT, on fromAddValid = 1 the block SHALL load Result <= fromAddOut, pulse Done[owner] for 1 cycle, clear toAddA/toAddB/toAddOp to 0, set the pointer to the owner, and enter IDLE.
REQ-023 Minimum latency SHALL be: Req sampled at edge N -> Gnt at N+1 -> toAddLoad at N+2; Done SHALL assert in the cycle after fromAddValid is sampled.
REQ-024 A requester SHALL hold Req and its operands until Gnt; Req dropped before Gnt SHALL cancel the request with no side effects.
REQ-025 Req still high in the cycle Done pulses SHALL start a new job from IDLE on the following edge, with no lost or duplicated jobs.
REQ-026 Gnt and Done SHALL be one-hot or zero in every cycle.

Reset
REQ-027 On Reset_n = 0, immediately and regardless of state, the block SHALL enter IDLE and clear Gnt, Done, Result, Busy, toAddA, toAddB, toAddOp and toAddLoad to 0, with the pointer favouring requester 0.
REQ-028 An in-flight job SHALL be dropped silently on reset, and a late fromAddValid after reset SHALL be ignored.

Configuration
REQ-029 With FP_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL run in WAIT; if it reaches 255 without fromAddValid, the block SHALL set Result to NAN (0_11111111_111...1 for 32-bit), pulse Done[owner] and enter IDLE.
REQ-030 Without FP_ARB_TIMEOUT_EN, WAIT SHALL persist indefinitely until fromAddValid arrives, and no counter SHALL be synthesised.

Structure
REQ-031 The shared package fp_pkg SHALL hold the PRECISION-dependent constants ZERO and NAN, the state enum (IDLE, ISSUE, WAIT) and the timeout limit 255.
REQ-032 The combinational 2-way round-robin pick SHALL be a sub-module named rr_pick2 (inputs Req and pointer, output one-hot grant).

Verification
REQ-033 Single job: Req=01, A=0x3F800000, B=0x40000000, op=0, adder Valid 3 cycles after Load -> Gnt=01 at N+1, Load at N+2, Done=01, Result=0x40400000.
REQ-034 Contention: Req=11 held from reset -> order Gnt 01, 10, 01, 10; Done order matches.
REQ-035 Back-to-back: Req=10 held continuously -> a new Gnt=10 on the edge after each Done, with no idle gap beyond IDLE.
REQ-036 Reset mid-job: Reset_n low in WAIT, Valid arrives afterwards -> no Done, all outputs 0, Busy=0.
REQ-037 Timeout (FP_ARB_TIMEOUT_EN defined): adder never valid -> Done after 255 WAIT cycles with Result=0x7FFFFFFF; without the macro, Busy stays 1 indefinitely.
REQ-038 Spurious Valid: fromAddValid=1 in IDLE/ISSUE -> ignored, no Done, Result unchanged.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: state encoding and shared constants for the floating-point adder
// arbiter. ZERO and NAN are stored 64 bits wide; users narrow them to their
// operand width. For 32-bit operands, nanFor() gives 0x7FFFFFFF.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbState_e;

  localparam int          TIMEOUT_LIMIT = 255;
  localparam logic [63:0] ZERO          = 64'h0000_0000_0000_0000;
  localparam logic [63:0] NAN           = 64'h7FFF_FFFF_FFFF_FFFF;

  // Positive quiet NaN with every exponent and mantissa bit set, sized to precision
  function automatic logic [63:0] nanFor(input int precision);
    return NAN >> (64 - precision);
  endfunction

endpackage

// File: rtl/fp_resource_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick. The pointer names the
// requester served last, so the other one wins a tie.
module rr_pick2 (
  input  logic [1:0] Req,
  input  logic       pointer,
  output logic [1:0] grant
);

  // A single request always wins; a tie goes to the requester not served last
  always_comb begin
    grant = 2'b00;
    case (Req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fp_resource_arbiter.sv
// fp_resource_arbiter: shares one external FP add/sub unit between two
// requesters. The flow is IDLE (grant and latch operands), ISSUE (start the
// adder), then WAIT (collect the result). Every output is registered.
// Optional build macro: FP_ARB_TIMEOUT_EN. It adds an 8-bit WAIT watchdog.
// If the watchdog expires, the job completes with a NaN result.
module fp_resource_arbiter
  import fp_pkg::*;
#(
  parameter int PRECISION = 32
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [1:0]             Req,
  input  logic [2*PRECISION-1:0] ReqA,
  input  logic [2*PRECISION-1:0] ReqB,
  input  logic [1:0]             ReqOp,
  output logic [1:0]             Gnt,
  output logic [1:0]             Done,
  output logic [PRECISION-1:0]   Result,
  output logic                   Busy,
  output logic [PRECISION-1:0]   toAddA,
  output logic [PRECISION-1:0]   toAddB,
  output logic                   toAddOp,
  output logic                   toAddLoad,
  input  logic                   fromAddValid,
  input  logic [PRECISION-1:0]   fromAddOut
);

  arbState_e              state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   owner_q, owner_d;
  logic [1:0]             gnt_q, gnt_d;
  logic [1:0]             done_q, done_d;
  logic [PRECISION-1:0]   result_q, result_d;
  logic                   busy_q, busy_d;
  logic [PRECISION-1:0]   addA_q, addA_d;
  logic [PRECISION-1:0]   addB_q, addB_d;
  logic                   addOp_q, addOp_d;
  logic                   load_q, load_d;
  logic [1:0]             pickGnt;
  logic                   jobEnd;
  logic [PRECISION-1:0]   endValue;

  rr_pick2 uPick (
    .Req     (Req),
    .pointer (ptr_q),
    .grant   (pickGnt)
  );

`ifdef FP_ARB_TIMEOUT_EN
  localparam logic [63:0] NanWide = nanFor(PRECISION);

  logic [7:0] cnt_q, cnt_d;
  logic       timeoutHit;

  assign timeoutHit = (state_q == WAIT) && (cnt_q == 8'(TIMEOUT_LIMIT));
  assign jobEnd     = fromAddValid || timeoutHit;
  assign endValue   = fromAddValid ? fromAddOut : NanWide[PRECISION-1:0];

  // The watchdog counts WAIT cycles and restarts from zero for every job
  always_comb begin
    cnt_d = (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
  end

  // Watchdog counter register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end
`else
  assign jobEnd   = fromAddValid;
  assign endValue = fromAddOut;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: accept any request, issue for one cycle, then wait for completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Req != 2'b00) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (jobEnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: grant and latch in IDLE, start pulse from ISSUE, retire in WAIT
  always_comb begin
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    load_d   = 1'b0;
    result_d = result_q;
    addA_d   = addA_q;
    addB_d   = addB_q;
    addOp_d  = addOp_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (Req != 2'b00) begin
          gnt_d   = pickGnt;
          owner_d = pickGnt[1];
          addA_d  = pickGnt[1] ? ReqA[PRECISION +: PRECISION] : ReqA[0 +: PRECISION];
          addB_d  = pickGnt[1] ? ReqB[PRECISION +: PRECISION] : ReqB[0 +: PRECISION];
          addOp_d = pickGnt[1] ? ReqOp[1] : ReqOp[0];
        end
      end
      ISSUE: load_d = 1'b1;
      WAIT: begin
        if (jobEnd) begin
          result_d = endValue;
          done_d   = owner_q ? 2'b10 : 2'b01;
          addA_d   = ZERO[PRECISION-1:0];
          addB_d   = ZERO[PRECISION-1:0];
          addOp_d  = 1'b0;
          ptr_d    = owner_q;
        end
      end
      default: ;
    endcase
  end

  // Output registers. After reset, the pointer names requester 1 as last served,
  // so requester 0 wins the first tie.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q    <= 1'b1;
      owner_q  <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= ZERO[PRECISION-1:0];
      busy_q   <= 1'b0;
      addA_q   <= ZERO[PRECISION-1:0];
      addB_q   <= ZERO[PRECISION-1:0];
      addOp_q  <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      addA_q   <= addA_d;
      addB_q   <= addB_d;
      addOp_q  <= addOp_d;
      load_q   <= load_d;
    end
  end

  assign Gnt       = gnt_q;
  assign Done      = done_q;
  assign Result    = result_q;
  assign Busy      = busy_q;
  assign toAddA    = addA_q;
  assign toAddB    = addB_q;
  assign toAddOp   = addOp_q;
  assign toAddLoad = load_q;

endmodule

// File: tb/tb_fp_resource_arbiter.sv
// tb_fp_resource_arbiter: directed bench for fp_resource_arbiter at 32-bit precision.
// A stub adder answers a fixed number of cycles after each start pulse.
// Expected grants and completions are queued when a request is driven.
// They are popped when the design pulses Gnt or Done.
module tb_fp_resource_arbiter;

  localparam int P = 32;

  typedef struct packed {
    logic [1:0]  done;
    logic [31:0] result;
  } expDone_t;

  logic           Clk;
  logic           Reset_n;
  logic [1:0]     Req;
  logic [2*P-1:0] ReqA;
  logic [2*P-1:0] ReqB;
  logic [1:0]     ReqOp;
  logic [1:0]     Gnt;
  logic [1:0]     Done;
  logic [P-1:0]   Result;
  logic           Busy;
  logic [P-1:0]   toAddA;
  logic [P-1:0]   toAddB;
  logic           toAddOp;
  logic           toAddLoad;
  logic           fromAddValid;
  logic [P-1:0]   fromAddOut;

  logic           stubValid;
  logic [P-1:0]   stubOut;
  logic [P-1:0]   stubResult;
  logic           forceValid;
  logic [P-1:0]   forceOut;
  logic           stubEnable;
  int             stubLatency;
  logic           monEnable;

  int             checks = 0;
  int             errors = 0;
  logic [1:0]     gntQ[$];
  expDone_t       doneQ[$];
  expDone_t       monExp;

  assign fromAddValid = stubValid | forceValid;
  assign fromAddOut   = stubValid ? stubOut : (forceValid ? forceOut : 32'hBAD0_0000);

  fp_resource_arbiter #(.PRECISION(P)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Req          (Req),
    .ReqA         (ReqA),
    .ReqB         (ReqB),
    .ReqOp        (ReqOp),
    .Gnt          (Gnt),
    .Done         (Done),
    .Result       (Result),
    .Busy         (Busy),
    .toAddA       (toAddA),
    .toAddB       (toAddB),
    .toAddOp      (toAddOp),
    .toAddLoad    (toAddLoad),
    .fromAddValid (fromAddValid),
    .fromAddOut   (fromAddOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Exact single-precision results for the operand pairs used below
  function automatic logic [31:0] fpModel(input logic [31:0] a, input logic [31:0] b, input logic op);
    case ({op, a, b})
      {1'b0, 32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {1'b0, 32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {1'b1, 32'h4040_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {1'b1, 32'h4080_0000, 32'h3F80_0000}: return 32'h4040_0000;
      default:                              return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req,
                               input logic [31:0] a0, input logic [31:0] b0, input logic op0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic op1);
    Req   = req;
    ReqA  = {a1, a0};
    ReqB  = {b1, b0};
    ReqOp = {op1, op0};
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_gnt"},    Gnt,       2'b00);
    checkOutput({tag, "_done"},   Done,      2'b00);
    checkOutput({tag, "_result"}, Result,    32'h0);
    checkOutput({tag, "_busy"},   Busy,      1'b0);
    checkOutput({tag, "_addA"},   toAddA,    32'h0);
    checkOutput({tag, "_addB"},   toAddB,    32'h0);
    checkOutput({tag, "_addOp"},  toAddOp,   1'b0);
    checkOutput({tag, "_load"},   toAddLoad, 1'b0);
  endtask

  task automatic waitDone(input int limit, output int cycles, output logic got);
    got    = 1'b0;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clk);
      cycles++;
      if (Done != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Stub adder: answers stubLatency cycles after each start pulse it sees
  initial begin
    stubValid  = 1'b0;
    stubOut    = '0;
    stubResult = '0;
    forever begin
      @(negedge Clk);
      if (stubEnable && toAddLoad) begin
        stubResult = fpModel(toAddA, toAddB, toAddOp);
        repeat (stubLatency) @(negedge Clk);
        stubValid = 1'b1;
        stubOut   = stubResult;
        @(negedge Clk);
        stubValid = 1'b0;
        stubOut   = '0;
      end
    end
  end

  // Monitor: one-hot pulses, grant order and completion order/results
  always @(negedge Clk) begin
    if (monEnable) begin
      checkOutput("gnt_onehot", $onehot0(Gnt), 1'b1);
      checkOutput("done_onehot", $onehot0(Done), 1'b1);
      if (Gnt != 2'b00) begin
        if (gntQ.size() == 0) checkOutput("gnt_unexpected", Gnt, 2'b00);
        else                  checkOutput("gnt_order", Gnt, gntQ.pop_front());
      end
      if (Done != 2'b00) begin
        if (doneQ.size() == 0) begin
          checkOutput("done_unexpected", Done, 2'b00);
        end else begin
          monExp = doneQ.pop_front();
          checkOutput("done_owner", Done, monExp.done);
          checkOutput("done_result", Result, monExp.result);
        end
      end
    end
  end

  initial begin
    int   cyc;
    logic got;
    int   nGnt;

    monEnable   = 1'b0;
    stubEnable  = 1'b1;
    stubLatency = 3;
    forceValid  = 1'b0;
    forceOut    = '0;
    Reset_n     = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    monEnable = 1'b1;
    checkReset("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    // Single job: 1.0 + 2.0 from requester 0
    $display("[TB] single job");
    gntQ.push_back(2'b01);
    doneQ.push_back(expDone_t'({2'b01, 32'h4040_0000}));
    applyStimulus(2'b01, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge Clk);
    checkOutput("single_gnt", Gnt, 2'b01);
    checkOutput("single_busy", Busy, 1'b1);
    checkOutput("single_opA", toAddA, 32'h3F80_0000);
    checkOutput("single_opB", toAddB, 32'h4000_0000);
    checkOutput("single_op", toAddOp, 1'b0);
    checkOutput("single_load_early", toAddLoad, 1'b0);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge Clk);
    checkOutput("single_load", toAddLoad, 1'b1);
    waitDone(20, cyc, got);
    checkOutput("single_done_seen", got, 1'b1);
    checkOutput("single_load_to_done", cyc, 4);
    @(negedge Clk);
    checkOutput("single_result_hold", Result, 32'h4040_0000);
    checkOutput("single_idle_busy", Busy, 1'b0);
    checkOutput("single_clear_opA", toAddA, 32'h0);
    checkOutput("single_clear_opB", toAddB, 32'h0);

    // Spurious adder valid in IDLE
    $display("[TB] spurious valid");
    forceValid = 1'b1;
    forceOut   = 32'h1234_5678;
    repeat (2) @(negedge Clk);
    forceValid = 1'b0;
    @(negedge Clk);
    checkOutput("spur_idle_done", Done, 2'b00);
    checkOutput("spur_idle_result", Result, 32'h4040_0000);
    checkOutput("spur_idle_busy", Busy, 1'b0);

    // Spurious adder valid in ISSUE, then a real job from requester 1
    gntQ.push_back(2'b10);
    doneQ.push_back(expDone_t'({2'b10, 32'h4080_0000}));
    applyStimulus(2'b10, 32'h0, 32'h0, 1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0);
    @(negedge Clk);
    checkOutput("spur_issue_gnt", Gnt, 2'b10);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    forceValid = 1'b1;
    forceOut   = 32'h1234_5678;
    @(negedge Clk);
    forceValid = 1'b0;
    checkOutput("spur_issue_load", toAddLoad, 1'b1);
    checkOutput("spur_issue_done", Done, 2'b00);
    @(negedge Clk);
    checkOutput("spur_issue_done2", Done, 2'b00);
    checkOutput("spur_issue_result", Result, 32'h4040_0000);
    waitDone(20, cyc, got);
    checkOutput("spur_issue_job_done", got, 1'b1);
    @(negedge Clk);

    // Contention: both requesters held from reset
    $display("[TB] contention");
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    stubLatency = 2;
    for (int k = 0; k < 2; k++) begin
      gntQ.push_back(2'b01);
      gntQ.push_back(2'b10);
      doneQ.push_back(expDone_t'({2'b01, 32'h4040_0000}));
      doneQ.push_back(expDone_t'({2'b10, 32'h4000_0000}));
    end
    applyStimulus(2'b11, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    nGnt = 0;
    for (int i = 0; i < 200 && nGnt < 4; i++) begin
      @(negedge Clk);
      if (Gnt != 2'b00) nGnt++;
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("cont_grants", nGnt, 4);
    for (int i = 0; i < 100 && doneQ.size() != 0; i++) @(negedge Clk);
    checkOutput("cont_done_drained", doneQ.size(), 0);
    checkOutput("cont_gnt_drained", gntQ.size(), 0);
    @(negedge Clk);

    // Back-to-back: requester 1 holds its request through three jobs
    $display("[TB] back-to-back");
    stubLatency = 3;
    for (int k = 0; k < 3; k++) begin
      gntQ.push_back(2'b10);
      doneQ.push_back(expDone_t'({2'b10, 32'h4080_0000}));
    end
    applyStimulus(2'b10, 32'h0, 32'h0, 1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0);
    @(negedge Clk);
    checkOutput("b2b_gnt_first", Gnt, 2'b10);
    for (int k = 0; k < 2; k++) begin
      waitDone(20, cyc, got);
      checkOutput("b2b_done_seen", got, 1'b1);
      @(negedge Clk);
      checkOutput("b2b_gnt_next", Gnt, 2'b10);
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    waitDone(20, cyc, got);
    checkOutput("b2b_done_last", got, 1'b1);
    @(negedge Clk);

    // Reset while in WAIT: the late adder answer must be ignored
    $display("[TB] reset mid-job");
    stubLatency = 6;
    gntQ.push_back(2'b01);
    applyStimulus(2'b01, 32'h4080_0000, 32'h3F80_0000, 1'b1, 32'h0, 32'h0, 1'b0);
    @(negedge Clk);
    checkOutput("rstjob_gnt", Gnt, 2'b01);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge Clk);
    checkOutput("rstjob_load", toAddLoad, 1'b1);
    @(negedge Clk);
    checkOutput("rstjob_busy", Busy, 1'b1);
    Reset_n = 1'b0;
    #1;
    checkReset("rst_mid");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (8) @(negedge Clk);
    checkReset("rst_after");

    // Adder that never answers
    $display("[TB] stalled adder");
    stubEnable = 1'b0;
    gntQ.push_back(2'b10);
    applyStimulus(2'b10, 32'h0, 32'h0, 1'b0, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    @(negedge Clk);
    checkOutput("stall_gnt", Gnt, 2'b10);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef FP_ARB_TIMEOUT_EN
    doneQ.push_back(expDone_t'({2'b10, 32'h7FFF_FFFF}));
    waitDone(400, cyc, got);
    checkOutput("timeout_done_seen", got, 1'b1);
    @(negedge Clk);
    checkOutput("timeout_busy", Busy, 1'b0);
`else
    repeat (300) @(negedge Clk);
    checkOutput("stall_busy", Busy, 1'b1);
    checkOutput("stall_result", Result, 32'h0);
`endif
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    checkOutput("final_gntq_empty", gntQ.size(), 0);
    checkOutput("final_doneq_empty", doneQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
